// File: rtl/pmbus_target_regs.sv
// pmbus_target_regs: PMBus/I2C target with a 2**RF_AW x 8 register file.
// Define PMBUS_TARGET_READ_EN to build the read path (RDATA/RDATA_ACK).
// Ports: clock/reset; scl_in/sda_in raw bus levels; sda_oe pulls SDA low;
// wr_strobe/wr_cmd/wr_data per written byte; busy from address match to
// STOP; rf_rd_addr/rf_rd_data registered fabric-side read port.
module pmbus_target_regs #(
  parameter logic [6:0] TARGET_ADDR = 7'h7B,
  parameter int         RF_AW       = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             scl_in,
  input  logic             sda_in,
  output logic             sda_oe,
  output logic             wr_strobe,
  output logic [7:0]       wr_cmd,
  output logic [7:0]       wr_data,
  output logic             busy,
  input  logic [RF_AW-1:0] rf_rd_addr,
  output logic [7:0]       rf_rd_data
);

  localparam int NREG = 1 << RF_AW;

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] CMD       = 4'd3;
  localparam logic [3:0] CMD_ACK   = 4'd4;
  localparam logic [3:0] WDATA     = 4'd5;
  localparam logic [3:0] WDATA_ACK = 4'd6;
  localparam logic [3:0] IGNORE    = 4'd7;
`ifdef PMBUS_TARGET_READ_EN
  localparam logic [3:0] RDATA     = 4'd8;
  localparam logic [3:0] RDATA_ACK = 4'd9;
`endif

  logic scl_m_q, scl_s_q, scl_p_q;
  logic sda_m_q, sda_s_q, sda_p_q;
  logic scl_rise, scl_fall, start, stop;

  logic [3:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [6:0]       sh_q, sh_d;
  logic [RF_AW-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, sda_oe_d;
  logic             busy_q, busy_d;
  logic             stb_q, stb_d;
  logic [7:0]       cmd_q, cmd_d;
  logic [7:0]       dat_q, dat_d;
  logic [7:0]       rd_q;
  logic [7:0]       rf_q [NREG];
`ifdef PMBUS_TARGET_READ_EN
  logic             rw_q, rw_d;
  logic [7:0]       tx_q, tx_d;
`endif

  logic [7:0] byte_in;
  logic       rx_done, addr_ok, cmd_ok, rf_we;

  // Synchronizers idle high so reset never fabricates a bus condition.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_m_q <= 1'b1;
      scl_s_q <= 1'b1;
      scl_p_q <= 1'b1;
      sda_m_q <= 1'b1;
      sda_s_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_m_q <= scl_in;
      scl_s_q <= scl_m_q;
      scl_p_q <= scl_s_q;
      sda_m_q <= sda_in;
      sda_s_q <= sda_m_q;
      sda_p_q <= sda_s_q;
    end
  end

  assign scl_rise = scl_s_q & ~scl_p_q;
  assign scl_fall = ~scl_s_q & scl_p_q;
  assign start    = scl_s_q & scl_p_q & sda_p_q & ~sda_s_q;
  assign stop     = scl_s_q & scl_p_q & ~sda_p_q & sda_s_q;

  assign byte_in = {sh_q, sda_s_q};
  assign rx_done = scl_rise && (cnt_q == 4'd7);
  assign cmd_ok  = (byte_in >> RF_AW) == 8'd0;
`ifdef PMBUS_TARGET_READ_EN
  assign addr_ok = byte_in[7:1] == TARGET_ADDR;
`else
  assign addr_ok = (byte_in[7:1] == TARGET_ADDR) && !byte_in[0];
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sh_d     = sh_q;
    ptr_d    = ptr_q;
    sda_oe_d = sda_oe_q;
    busy_d   = busy_q;
    stb_d    = 1'b0;
    cmd_d    = cmd_q;
    dat_d    = dat_q;
    rf_we    = 1'b0;
`ifdef PMBUS_TARGET_READ_EN
    rw_d     = rw_q;
    tx_d     = tx_q;
`endif
    if (stop) begin
      state_d  = IDLE;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        ADDR, CMD, WDATA: begin
          if (scl_rise) begin
            sh_d  = byte_in[6:0];
            cnt_d = cnt_q + 4'd1;
          end
          if (rx_done) begin
            cnt_d = '0;
            if (state_q == ADDR) begin
              if (addr_ok) begin
                state_d = ADDR_ACK;
                busy_d  = 1'b1;
`ifdef PMBUS_TARGET_READ_EN
                rw_d    = byte_in[0];
`endif
              end else begin
                state_d = IGNORE;
              end
            end else if (state_q == CMD) begin
              if (cmd_ok) begin
                ptr_d   = byte_in[RF_AW-1:0];
                state_d = CMD_ACK;
              end else begin
                state_d = IGNORE;
              end
            end else begin
              rf_we   = 1'b1;
              stb_d   = 1'b1;
              cmd_d   = 8'(ptr_q);
              dat_d   = byte_in;
              ptr_d   = ptr_q + 1'b1;
              state_d = WDATA_ACK;
            end
          end
        end
        // First fall drives ACK, second fall (after the 9th clock) ends it.
        ADDR_ACK, CMD_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_oe_d = 1'b1;
              cnt_d    = 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = (state_q == ADDR_ACK) ? CMD : WDATA;
`ifdef PMBUS_TARGET_READ_EN
              if (state_q == ADDR_ACK && rw_q) begin
                tx_d     = rf_q[ptr_q];
                sda_oe_d = ~rf_q[ptr_q][7];
                state_d  = RDATA;
              end
`endif
            end
          end
        end
`ifdef PMBUS_TARGET_READ_EN
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = RDATA_ACK;
            end else begin
              sda_oe_d = ~tx_q[~cnt_q[2:0]];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise && cnt_q == 4'd0) begin
            if (!sda_s_q) begin
              ptr_d = ptr_q + 1'b1;
              cnt_d = 4'd1;
            end else begin
              state_d = IGNORE;
            end
          end
          if (scl_fall && cnt_q == 4'd1) begin
            tx_d     = rf_q[ptr_q];
            sda_oe_d = ~rf_q[ptr_q][7];
            cnt_d    = '0;
            state_d  = RDATA;
          end
        end
`endif
        IDLE, IGNORE: state_d = state_q;
        default:      state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      ptr_q    <= '0;
      sda_oe_q <= 1'b0;
      busy_q   <= 1'b0;
      stb_q    <= 1'b0;
      cmd_q    <= '0;
      dat_q    <= '0;
`ifdef PMBUS_TARGET_READ_EN
      rw_q     <= 1'b0;
      tx_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      ptr_q    <= ptr_d;
      sda_oe_q <= sda_oe_d;
      busy_q   <= busy_d;
      stb_q    <= stb_d;
      cmd_q    <= cmd_d;
      dat_q    <= dat_d;
`ifdef PMBUS_TARGET_READ_EN
      rw_q     <= rw_d;
      tx_q     <= tx_d;
`endif
    end
  end

  // Read port samples before the write lands: same-index write reads old.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_q <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rd_q <= rf_q[rf_rd_addr];
      if (rf_we) begin
        rf_q[ptr_q] <= byte_in;
      end
    end
  end

  assign sda_oe     = sda_oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = stb_q;
  assign wr_cmd     = cmd_q;
  assign wr_data    = dat_q;
  assign rf_rd_data = rd_q;

endmodule

// File: tb/tb_pmbus_target_regs.sv
// tb_pmbus_target_regs: bus-level controller model plus register-file
// reference for pmbus_target_regs (directed cases + random transactions).
`timescale 1ns/1ps
module tb_pmbus_target_regs;

  localparam int H = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ctrl_scl = 1'b1;
  logic ctrl_sda = 1'b1;
  logic sda_line;
  logic sda_oe, wr_strobe, busy;
  logic [7:0] wr_cmd, wr_data, rf_rd_data;
  logic [5:0] rf_rd_addr = '0;

  assign sda_line = ctrl_sda & ~sda_oe;

  pmbus_target_regs dut (
    .clock      (clock),
    .reset      (reset),
    .scl_in     (ctrl_scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .wr_strobe  (wr_strobe),
    .wr_cmd     (wr_cmd),
    .wr_data    (wr_data),
    .busy       (busy),
    .rf_rd_addr (rf_rd_addr),
    .rf_rd_data (rf_rd_data)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  int stb_cnt = 0;
  int oe_cnt = 0;
  logic [23:0] stb_log [1024];

  always @(negedge clock) begin
    if (wr_strobe) begin
      stb_log[stb_cnt % 1024] = {rf_rd_data, wr_cmd, wr_data};
      stb_cnt++;
    end
    if (sda_oe) oe_cnt++;
  end

  logic [7:0] mref [64];
  logic [5:0] mptr;
  logic [7:0] tx [4];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mref[i] = 8'h00;
    mptr = '0;
  endtask

  task automatic bus_start();
    ctrl_sda = 1'b1; wclk(H);
    ctrl_scl = 1'b1; wclk(H);
    ctrl_sda = 1'b0; wclk(H);
    ctrl_scl = 1'b0; wclk(H);
  endtask

  task automatic bus_stop();
    ctrl_sda = 1'b0; wclk(H);
    ctrl_scl = 1'b1; wclk(H);
    ctrl_sda = 1'b1; wclk(H);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      ctrl_sda = b[i]; wclk(H);
      ctrl_scl = 1'b1; wclk(H);
      ctrl_scl = 1'b0; wclk(H);
    end
    ctrl_sda = 1'b1;
  endtask

  task automatic ack_high(output logic ack);
    ctrl_scl = 1'b1; wclk(H);
    ack = ~sda_line;
    ctrl_scl = 1'b0; wclk(H);
  endtask

  task automatic ack_clk(output logic ack);
    wclk(H);
    ack_high(ack);
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] idx);
    rf_rd_addr = idx;
    wclk(1);
    check(tag, rf_rd_data, mref[idx]);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 64; i++) rd_chk($sformatf("%s[%0d]", tag, i), 6'(i));
  endtask

  // Write transaction: address, command, then n bytes from tx[].
  task automatic wr_xact(input string tag, input logic [7:0] a,
                         input logic [7:0] c, input int n);
    logic ack;
    logic a_ok, c_ok;
    int base, oe0;
    base = stb_cnt;
    oe0 = oe_cnt;
    a_ok = (a[7:1] == 7'h7B) && !a[0];
    c_ok = a_ok && (c < 8'd64);
    bus_start();
    send_bits(a); ack_clk(ack);
    check({tag, ":addr_ack"}, ack, a_ok);
    check({tag, ":busy"}, busy, a_ok);
    send_bits(c); ack_clk(ack);
    check({tag, ":cmd_ack"}, ack, c_ok);
    if (c_ok) mptr = c[5:0];
    for (int i = 0; i < n; i++) begin
      send_bits(tx[i]); ack_clk(ack);
      check($sformatf("%s:d%0d_ack", tag, i), ack, c_ok);
      if (c_ok) begin
        check($sformatf("%s:d%0d_stb", tag, i),
              stb_log[(stb_cnt + 1023) % 1024],
              {mref[rf_rd_addr], 2'b00, mptr, tx[i]});
        mref[mptr] = tx[i];
        mptr = mptr + 6'd1;
      end
    end
    bus_stop();
    check({tag, ":n_stb"}, stb_cnt - base, c_ok ? n : 0);
    check({tag, ":busy_end"}, busy, 1'b0);
    check({tag, ":oe_end"}, sda_oe, 1'b0);
    if (!a_ok) check({tag, ":oe_quiet"}, oe_cnt - oe0, 0);
  endtask

`ifdef PMBUS_TARGET_READ_EN
  task automatic recv_byte(input logic give_ack, output logic [7:0] v);
    v = '0;
    for (int i = 7; i >= 0; i--) begin
      ctrl_sda = 1'b1; wclk(H);
      ctrl_scl = 1'b1; wclk(H);
      v[i] = sda_line;
      ctrl_scl = 1'b0; wclk(H);
    end
    ctrl_sda = ~give_ack; wclk(H);
    ctrl_scl = 1'b1; wclk(H);
    ctrl_scl = 1'b0; wclk(1);
    ctrl_sda = 1'b1; wclk(H - 1);
  endtask

  task automatic rd_xact(input string tag, input logic [5:0] p0, input int n);
    logic ack;
    logic [7:0] v;
    bus_start();
    send_bits(8'hF6); ack_clk(ack);
    check({tag, ":waddr_ack"}, ack, 1'b1);
    send_bits({2'b00, p0}); ack_clk(ack);
    check({tag, ":ptr_ack"}, ack, 1'b1);
    mptr = p0;
    bus_start();
    send_bits(8'hF7); ack_clk(ack);
    check({tag, ":raddr_ack"}, ack, 1'b1);
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, v);
      check($sformatf("%s:rd%0d", tag, i), v, mref[mptr]);
      if (i < n - 1) mptr = mptr + 6'd1;
    end
    check({tag, ":oe_rel"}, sda_oe, 1'b0);
    bus_stop();
    check({tag, ":busy_end"}, busy, 1'b0);
  endtask
`else
  task automatic rd_nack(input string tag);
    logic ack;
    int oe0;
    oe0 = oe_cnt;
    bus_start();
    send_bits(8'hF7); ack_clk(ack);
    check({tag, ":raddr_nack"}, ack, 1'b0);
    bus_stop();
    check({tag, ":oe_quiet"}, oe_cnt - oe0, 0);
  endtask
`endif

  initial begin
    #(950_000);
    $display("FAIL watchdog timeout after %0d checks", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    int base, r, n;
    logic [7:0] a, c;
    model_clear();

    wclk(4);
    check("rst:sda_oe", sda_oe, 1'b0);
    check("rst:busy", busy, 1'b0);
    check("rst:wr_strobe", wr_strobe, 1'b0);
    check("rst:wr_cmd", wr_cmd, 8'h00);
    check("rst:wr_data", wr_data, 8'h00);
    check("rst:rf_rd_data", rf_rd_data, 8'h00);
    reset = 1'b0;
    wclk(4);

    rf_rd_addr = 6'h24;
    tx[0] = 8'h35; tx[1] = 8'hE8;
    wr_xact("basic", 8'hF6, 8'h24, 2);
    rd_chk("basic:rd25", 6'h25);

    tx[0] = 8'h11; tx[1] = 8'h22;
    wr_xact("wrap", 8'hF6, 8'h3F, 2);
    rd_chk("wrap:rd63", 6'h3F);
    rd_chk("wrap:rd0", 6'h00);

    wr_xact("badaddr", 8'hA0, 8'h00, 0);
    tx[0] = 8'h5A;
    wr_xact("badcmd", 8'hF6, 8'h80, 1);

`ifdef PMBUS_TARGET_READ_EN
    rd_xact("read", 6'h01, 2);
`else
    rd_nack("read");
`endif

    // Reset lands while the target is driving the ACK of data byte 0x35.
    rf_rd_addr = 6'h10;
    bus_start();
    send_bits(8'hF6); ack_clk(ack);
    check("rmid:addr_ack", ack, 1'b1);
    send_bits(8'h24); ack_clk(ack);
    check("rmid:cmd_ack", ack, 1'b1);
    mptr = 6'h24;
    base = stb_cnt;
    send_bits(8'h35); wclk(H);
    check("rmid:oe_pre", sda_oe, 1'b1);
    check("rmid:stb", stb_log[(stb_cnt + 1023) % 1024],
          {mref[rf_rd_addr], 8'h24, 8'h35});
    reset = 1'b1;
    #1;
    check("rmid:oe_async", sda_oe, 1'b0);
    model_clear();
    wclk(3);
    check("rmid:busy", busy, 1'b0);
    check("rmid:wr_cmd", wr_cmd, 8'h00);
    check("rmid:wr_data", wr_data, 8'h00);
    reset = 1'b0;
    wclk(2);
    ack_high(ack);
    check("rmid:ack35", ack, 1'b0);
    send_bits(8'h44); ack_clk(ack);
    check("rmid:ack44", ack, 1'b0);
    send_bits(8'h55); ack_clk(ack);
    check("rmid:ack55", ack, 1'b0);
    check("rmid:busy_after", busy, 1'b0);
    bus_stop();
    check("rmid:n_stb", stb_cnt - base, 1);
    sweep("rmid:rf");
    tx[0] = 8'hC3;
    wr_xact("rmid:resume", 8'hF6, 8'h07, 1);

    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      n = $urandom_range(0, 4);
      for (int i = 0; i < 4; i++) tx[i] = 8'($urandom);
      rf_rd_addr = 6'($urandom);
      c = 8'($urandom_range(0, 63));
      a = 8'hF6;
      if (r == 0) begin
        a = {7'($urandom_range(0, 127)), 1'b0};
        if (a[7:1] == 7'h7B) a = 8'hA0;
      end else if (r == 1) begin
        c = 8'($urandom_range(64, 255));
      end
      if (r == 2) begin
`ifdef PMBUS_TARGET_READ_EN
        rd_xact($sformatf("rnd%0d", k), 6'($urandom), $urandom_range(1, 3));
`else
        rd_nack($sformatf("rnd%0d", k));
`endif
      end else begin
        wr_xact($sformatf("rnd%0d", k), a, c, n);
      end
    end

    sweep("final:rf");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
